// File: rtl/hdr_fp_pkg.sv
// rtl/hdr_fp_pkg.sv - shared constants and FSM encoding for the HDR fixed-point blocks
package hdr_fp_pkg;

  localparam int N      = 32;
  localparam int FP     = 4;
  localparam int ITER_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp_pack.sv
// rtl/fp_pack.sv - formats a 2N-bit raw product into QN-FP.FP plus overflow flag
// Rounding is half-up when MUL_ROUND_EN is defined, truncation otherwise.
module fp_pack
  import hdr_fp_pkg::*;
(
  input  logic [2*N-1:0] prod,
  output logic [N-1:0]   out,
  output logic           ovf
);

  logic high_bits;
  assign high_bits = |prod[2*N-1:N+FP];

`ifdef MUL_ROUND_EN
  logic [N:0] rounded;
  logic [FP-2:0] unused_lsbs;
  assign unused_lsbs = prod[FP-2:0];
  assign rounded = {1'b0, prod[N+FP-1:FP]} + {{N{1'b0}}, prod[FP-1]};
  assign out     = rounded[N-1:0];
  // A carry out of the rounding increment is an overflow just like lost high bits.
  assign ovf     = high_bits | rounded[N];
`else
  logic [FP-1:0] unused_lsbs;
  assign unused_lsbs = prod[FP-1:0];
  assign out = prod[N+FP-1:FP];
  assign ovf = high_bits;
`endif

endmodule

// File: rtl/mul_32bit_4fp_seq.sv
// rtl/mul_32bit_4fp_seq.sv - radix-2 shift-add Q28.4 multiplier with start/done handshake
// Optional half-up rounding via MUL_ROUND_EN (implemented inside fp_pack).
module mul_32bit_4fp_seq
  import hdr_fp_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         valid,
  output logic [N-1:0] OUT,
  output logic         ovrflow,
  output logic         ready,
  output logic         busy
);

  state_t state, next_state;

  logic [2*N-1:0]    m;
  logic [2*N-1:0]    p;
  logic [N-1:0]      q;
  logic [ITER_W-1:0] cnt;
  logic [N-1:0]      fmt_out;
  logic              fmt_ovf;

  fp_pack u_fp_pack (
    .prod (p),
    .out  (fmt_out),
    .ovf  (fmt_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (valid) next_state = CALC;
      CALC:    if (cnt == ITER_W'(N - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m       <= '0;
      p       <= '0;
      q       <= '0;
      cnt     <= '0;
      OUT     <= '0;
      ovrflow <= 1'b0;
      ready   <= 1'b0;
    end else begin
      ready <= (state == DONE);
      case (state)
        IDLE: begin
          if (valid) begin
            m   <= {{N{1'b0}}, A};
            q   <= B;
            p   <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          if (q[0]) p <= p + m;
          m   <= m << 1;
          q   <= q >> 1;
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          OUT     <= fmt_out;
          ovrflow <= fmt_ovf;
        end
        default: ;
      endcase
    end
  end

  // Stays high through the ready cycle so it falls together with ready.
  assign busy = (state != IDLE) || ready;

endmodule

// File: tb/tb_mul_32bit_4fp_seq.sv
// tb/tb_mul_32bit_4fp_seq.sv - self-checking bench for mul_32bit_4fp_seq
module tb_mul_32bit_4fp_seq;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic        valid;
  logic [31:0] OUT;
  logic        ovrflow;
  logic        ready;
  logic        busy;

  int checks;
  int errors;

  mul_32bit_4fp_seq dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .valid   (valid),
    .OUT     (OUT),
    .ovrflow (ovrflow),
    .ready   (ready),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer product scaled back by 2^4.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    logic [63:0] scaled;
    prod = 64'(a) * 64'(b);
`ifdef MUL_ROUND_EN
    scaled = (prod + 64'd8) / 64'd16;
`else
    scaled = prod / 64'd16;
`endif
    return {(scaled >= 64'h1_0000_0000), scaled[31:0]};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a; B = b; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    A = $urandom; B = $urandom;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (!ready && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; A = '0; B = '0; valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({OUT, ovrflow, ready, busy} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got OUT=%h ovf=%b ready=%b busy=%b want all 0", OUT, ovrflow, ready, busy);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    start_op(32'h18, 32'h20);
    wait_ready(lat);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL basic_latency got %0d want 33", lat); end
    checks++;
    if (OUT !== 32'h30 || ovrflow !== 1'b0) begin
      errors++; $display("FAIL basic_result got %h/%b want 00000030/0", OUT, ovrflow);
    end
  endtask

  task automatic test_overflow;
    int lat;
    start_op(32'hFFFF_FFFF, 32'h20);
    wait_ready(lat);
    checks++;
    if (OUT !== 32'hFFFF_FFFE || ovrflow !== 1'b1) begin
      errors++; $display("FAIL overflow_wrap got %h/%b want fffffffe/1", OUT, ovrflow);
    end
  endtask

  task automatic test_round;
    int lat;
    logic [31:0] want;
`ifdef MUL_ROUND_EN
    want = 32'h1;
`else
    want = 32'h0;
`endif
    start_op(32'h1, 32'h8);
    wait_ready(lat);
    checks++;
    if (OUT !== want || ovrflow !== 1'b0) begin
      errors++; $display("FAIL round_half got %h/%b want %h/0", OUT, ovrflow, want);
    end
  endtask

  task automatic test_valid_ignored;
    int ready_cnt;
    int busy_gap;
    int first_lat;
    logic seen;
    start_op(32'h0, 32'hDEAD_BEEF);
    repeat (9) @(posedge clk);
    #1;
    A = 32'h100; B = 32'h100; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    ready_cnt = 0; busy_gap = 0; first_lat = 0; seen = 1'b0;
    for (int i = 11; i <= 90; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        ready_cnt++;
        if (!seen) first_lat = i;
        seen = 1'b1;
      end
      if (!seen && !busy) busy_gap++;
    end
    checks++;
    if (ready_cnt !== 1) begin errors++; $display("FAIL ignored_ready_count got %0d want 1", ready_cnt); end
    checks++;
    if (busy_gap !== 0) begin errors++; $display("FAIL ignored_busy_gap got %0d low cycles want 0", busy_gap); end
    checks++;
    if (first_lat !== 33) begin errors++; $display("FAIL ignored_latency got %0d want 33", first_lat); end
    checks++;
    if (OUT !== 32'h0 || ovrflow !== 1'b0) begin
      errors++; $display("FAIL zero_product got %h/%b want 00000000/0", OUT, ovrflow);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int stale;
    start_op(32'h1234_5678, 32'h9ABC);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({OUT, ovrflow, ready, busy} !== 35'd0) begin
      errors++;
      $display("FAIL midreset_outputs got OUT=%h ovf=%b ready=%b busy=%b want all 0", OUT, ovrflow, ready, busy);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready || busy) stale++;
    end
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL midreset_stale got %0d active cycles want 0", stale); end
    start_op(32'h30, 32'h30);
    wait_ready(lat);
    checks++;
    if (lat !== 33 || OUT !== 32'h90 || ovrflow !== 1'b0) begin
      errors++; $display("FAIL midreset_recover got lat=%0d %h/%b want 33 00000090/0", lat, OUT, ovrflow);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int held_bad;
    logic [32:0] exp1;
    logic [32:0] exp2;
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom; b1 = $urandom_range(32'hFFFF, 0);
    a2 = $urandom_range(32'hFFFFF, 0); b2 = $urandom;
    exp1 = model(a1, b1);
    exp2 = model(a2, b2);
    start_op(a1, b1);
    wait_ready(lat);
    checks++;
    if ({ovrflow, OUT} !== exp1) begin
      errors++; $display("FAIL b2b_first got %b/%h want %b/%h", ovrflow, OUT, exp1[32], exp1[31:0]);
    end
    A = a2; B = b2; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    held_bad = 0;
    lat = 1;
    while (!ready && lat < 100) begin
      if ({ovrflow, OUT} !== exp1) held_bad++;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL b2b_spacing got %0d want 34", lat); end
    checks++;
    if (held_bad !== 0) begin errors++; $display("FAIL b2b_hold got %0d changed cycles want 0", held_bad); end
    checks++;
    if ({ovrflow, OUT} !== exp2) begin
      errors++; $display("FAIL b2b_second got %b/%h want %b/%h", ovrflow, OUT, exp2[32], exp2[31:0]);
    end
  endtask

  task automatic test_random;
    int lat;
    logic [32:0] exp;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(32'hFFFF, 0); b = $urandom_range(32'hFFFF, 0); end
        default: begin a = $urandom_range(32'h3F, 0); b = $urandom_range(32'h3F, 0); end
      endcase
      exp = model(a, b);
      start_op(a, b);
      wait_ready(lat);
      checks++;
      if (lat !== 33 || {ovrflow, OUT} !== exp) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h got lat=%0d %b/%h want 33 %b/%h",
                 i, a, b, lat, ovrflow, OUT, exp[32], exp[31:0]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_basic;
    test_overflow;
    test_round;
    test_valid_ignored;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_32bit_4fp_seq.md
# mul_32bit_4fp_seq

Sequential unsigned fixed-point multiplier for the HDR pipeline: Q28.4 × Q28.4 → Q28.4, the multiplicative counterpart to the pipeline's 32-bit/4-fractional-bit divider. It applies exposure weights and scale factors to pixel radiance values that the divider produced, such as weighted sums and normalisation reciprocals. It uses a radix-2 shift-add datapath with a start/done handshake matching the divider's, so that upstream control FSMs can drive either block identically.

## Interface
- `N`, 32, operand and result width
- `FP`, 4, fractional bits in operands and result
- `clk` input 1 system clock; all state updates on rising edge
- `rst` input 1 asynchronous, active-high reset
- `A` input N multiplicand, unsigned QN-FP.FP; sampled only on accept
- `B` input N multiplier, unsigned QN-FP.FP; sampled only on accept
- `valid` input 1 start request; accepted only in IDLE
- `OUT` output N product, unsigned QN-FP.FP; reset value 0
- `ovrflow` output 1 high when the true result does not fit in N bits; reset value 0
- `ready` output 1 one-cycle pulse marking OUT/ovrflow as new; reset value 0
- `busy` output 1 high in CALC and DONE; reset value 0

## Operation
- FSM states: IDLE, CALC, DONE. Reset forces IDLE, clears all registers and outputs.
- IDLE: if `valid`=1, latch A into multiplicand reg M (2N bits, zero-extended). Latch B into shift reg Q. Clear accumulator P (2N bits) and iteration counter (6 bits). Go to CALC.
- CALC: each cycle, if Q[0] then P ← P + M. Then M ← M << 1, Q ← Q >> 1, and the counter increments. After N iterations, go to DONE.
- DONE: register the formatted result, pulse `ready`, return to IDLE next cycle.
- Formatting: OUT = P[N+FP-1:FP] (truncation toward zero); ovrflow = |P[2N-1:N+FP].
- On overflow, OUT still carries the low N bits of the shifted product (wrapping, no saturation).
- `valid` in CALC/DONE is ignored and not queued; the caller must wait for `ready`.
- OUT and ovrflow hold their values until the next DONE. They are not cleared on accept.
- Reset mid-operation: immediate return to IDLE; no `ready` pulse for the aborted operation.

## Timing
- Accept at edge k (IDLE, valid=1) → CALC during edges k+1..k+N → DONE at edge k+N+1.
- `ready`=1 for the single cycle after edge k+N+1, so latency is N+1 = 33 clocks.
- Earliest next accept is edge k+N+2. Throughput is one product per N+2 = 34 clocks.
- `busy` rises the cycle after accept and falls together with `ready`.
- Operands may change freely after the accept edge.
- OUT/ovrflow change only on the DONE edge and are stable whenever `ready`=1.

## Configuration
- `MUL_ROUND_EN` defined: round half-up.
  - OUT = P[N+FP-1:FP] + P[FP-1].
  - A carry out of that addition also sets ovrflow.
  - Latency is unchanged, since the addition happens in the DONE formatting.
- Not defined: pure truncation as described in Operation.

## Structure
- Shared package `hdr_fp_pkg`:
  - constants N=32, FP=4, ITER_W=6;
  - FSM state typedef/encoding (IDLE=0, CALC=1, DONE=2).
  - The divider wrapper's constants are to be moved here as well.
- One sub-module, `fp_pack`: combinational formatter taking the 2N-bit product and producing OUT/ovrflow. It contains the `MUL_ROUND_EN` rounding, so the same logic is reusable for the divider's output.
- The FSM, shift registers and accumulator live in the top module.

## Test plan
- A=0x18 (1.5), B=0x20 (2.0), valid one cycle → `ready` exactly 33 clocks after accept, OUT=0x30, ovrflow=0.
- A=0xFFFFFFFF, B=0x20 → OUT=0xFFFFFFFE, ovrflow=1.
- A=0x1, B=0x8 (raw product 0x8) → OUT=0x0 without `MUL_ROUND_EN`, OUT=0x1 with it; ovrflow=0 in both cases.
- A=0x0, B=0xDEADBEEF → OUT=0, ovrflow=0. A second `valid` pulsed at cycle 10 of CALC → ignored: exactly one `ready` pulse, `busy` continuous.
- Assert `rst` at CALC cycle 15, release, then issue A=0x30, B=0x30 → all outputs 0 during reset, no stale `ready`, then OUT=0x90 after 33 clocks.
- Back-to-back: accept again on the first cycle after `ready` → second `ready` exactly 34 clocks after the first; previous OUT held until then.
